// File: rtl/counter_bank_if.sv
// Control and status bundle for counter_bank: per-channel controls in,
// registered counter values, terminal-count pulses and directions out.
interface counter_bank_if #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       clear;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*WIDTH-1:0] load_value;
  logic [NUM_CH*WIDTH-1:0] limit;
  logic [NUM_CH*2-1:0]     mode;
  logic [NUM_CH*WIDTH-1:0] count;
  logic [NUM_CH-1:0]       tc;
  logic [NUM_CH-1:0]       dir;

  modport master (
    output en, clear, load, load_value, limit, mode,
    input  count, tc, dir
  );

  modport slave (
    input  en, clear, load, load_value, limit, mode,
    output count, tc, dir
  );
endinterface

// File: rtl/counter_bank.sv
// Bank of NUM_CH independent WIDTH-bit counters, each with its own
// clear/load/enable, limit, counting mode and terminal-count pulse.
module counter_bank #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 4
) (
  input  logic          clk,
  input  logic          resetn,
  counter_bank_if.slave bus
);

  typedef enum logic [1:0] {
    M_UP_WRAP   = 2'b00,
    M_UP_SAT    = 2'b01,
    M_DOWN_WRAP = 2'b10,
    M_PING_PONG = 2'b11
  } mode_e;

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             dir;
  } ch_state_t;

  logic [NUM_CH*WIDTH-1:0] count_q, count_d;
  logic [NUM_CH-1:0]       tc_q, tc_d;
  logic [NUM_CH-1:0]       dir_q, dir_d;

  // Next state of one channel; priority is clear > load > en.
  function automatic ch_state_t step(
    input logic [WIDTH-1:0] c,
    input logic             d,
    input logic             clr,
    input logic             ld,
    input logic             ena,
    input logic [WIDTH-1:0] lv,
    input logic [WIDTH-1:0] lim,
    input mode_e            m
  );
    ch_state_t s;
    s.cnt = c;
    s.tc  = 1'b0;
    s.dir = d;
    if (clr) begin
      s.cnt = '0;
      s.dir = 1'b1;
    end else if (ld) begin
      s.cnt = lv;
    end else if (ena) begin
      case (m)
        M_UP_WRAP: begin
          if (c >= lim) begin
            s.cnt = '0;
            s.tc  = 1'b1;
          end else begin
            s.cnt = c + 1'b1;
          end
        end
        M_UP_SAT: begin
          if (c < lim) begin
            s.cnt = c + 1'b1;
            s.tc  = ((c + 1'b1) == lim);
          end
        end
        M_DOWN_WRAP: begin
          if (c == '0) begin
            s.cnt = lim;
            s.tc  = 1'b1;
          end else begin
            s.cnt = c - 1'b1;
          end
        end
        M_PING_PONG: begin
          if (d) begin
            if (c >= lim) begin
              s.dir = 1'b0;
              s.tc  = 1'b1;
              s.cnt = (c == '0) ? c : c - 1'b1;
            end else begin
              s.cnt = c + 1'b1;
            end
          end else begin
            if (c == '0) begin
              s.dir = 1'b1;
              s.tc  = 1'b1;
              s.cnt = (lim == '0) ? '0 : WIDTH'(1);
            end else begin
              s.cnt = c - 1'b1;
            end
          end
        end
      endcase
    end
    return s;
  endfunction

  always_comb begin
    count_d = count_q;
    tc_d    = '0;
    dir_d   = dir_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      {count_d[i*WIDTH +: WIDTH], tc_d[i], dir_d[i]} = step(
        count_q[i*WIDTH +: WIDTH],
        dir_q[i],
        bus.clear[i],
        bus.load[i],
        bus.en[i],
        bus.load_value[i*WIDTH +: WIDTH],
        bus.limit[i*WIDTH +: WIDTH],
        mode_e'(bus.mode[i*2 +: 2])
      );
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      tc_q    <= '0;
      dir_q   <= '1;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      dir_q   <= dir_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.dir   = dir_q;

endmodule
